// File: rtl/zle_sched2.sv
// Two-producer front end for a zero run-length encoder: muxes A/B onto one stream
// and only hands the grant over where no zero run is open inside the encoder.
module zle_sched2 #(
   parameter int W    = 3,
   parameter int MAXZ = 16,
   parameter int MAXG = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] a_d,
   input  logic         a_v,
   output logic         a_b,
   input  logic [W-1:0] b_d,
   input  logic         b_v,
   output logic         b_b,
   output logic [W-1:0] o_d,
   output logic         o_v,
   input  logic         o_b,
   output logic         o_s,
   output logic         gnt
);

   localparam int ZW = $clog2(MAXZ + 1);
   localparam int TW = $clog2(MAXG + 1);

   typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

   owner_t        owner, owner_nx;
   logic          lock, lock_nx;
   logic [ZW-1:0] zrun, zrun_nx;
   logic [TW-1:0] tcnt, tcnt_nx;

   logic          own_v, oth_v, own_b, sw, xfer;
   logic [W-1:0]  own_d;

   assign own_v = (owner == OWN_B) ? b_v : a_v;
   assign oth_v = (owner == OWN_B) ? a_v : b_v;
   assign own_d = (owner == OWN_B) ? b_d : a_d;

   // Hand-over costs one bubble cycle: nothing transfers while sw is high.
   assign sw    = !reset && !lock && oth_v && (!own_v || (tcnt == TW'(MAXG)));
   assign o_v   = !reset && own_v && !sw;
   assign own_b = reset || o_b || sw;
   assign xfer  = o_v && !o_b;

   assign a_b = reset || (owner != OWN_A) || own_b;
   assign b_b = reset || (owner != OWN_B) || own_b;
   assign o_d = own_d;
   assign gnt = owner;
   assign o_s = gnt;

   always_comb begin
      owner_nx = owner;
      lock_nx  = lock;
      zrun_nx  = zrun;
      tcnt_nx  = tcnt;
      if (sw) begin
         owner_nx = (owner == OWN_A) ? OWN_B : OWN_A;
         lock_nx  = 1'b0;
         zrun_nx  = '0;
         tcnt_nx  = '0;
      end else if (xfer) begin
         if (tcnt != TW'(MAXG))
            tcnt_nx = tcnt + 1'b1;
         // A run that reaches MAXZ is flushed by the encoder, so it closes here.
         if ((own_d == '0) && (zrun != ZW'(MAXZ - 1))) begin
            zrun_nx = zrun + 1'b1;
            lock_nx = 1'b1;
         end else begin
            zrun_nx = '0;
            lock_nx = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner <= OWN_A;
         lock  <= 1'b0;
         zrun  <= '0;
         tcnt  <= '0;
      end else begin
         owner <= owner_nx;
         lock  <= lock_nx;
         zrun  <= zrun_nx;
         tcnt  <= tcnt_nx;
      end
   end

endmodule
